// File: rtl/fb_packet_fifo_pkg.sv
// Shared frontend/backend packet types and the default FIFO depth.
package bundle;

   localparam int FB_FIFO_DEPTH = 8;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } frontend_packet_t;

endpackage

// File: rtl/fb_packet_fifo_if.sv
// Frontend-to-backend packet channel: the frontend push side and the backend pop side.
interface fb_packet_fifo_if
   import bundle::*;
#(
   parameter int PTR_W = $clog2(FB_FIFO_DEPTH)
);

   logic             flush;
   frontend_packet_t in_packet;
   logic             frontend_busy;
   logic             backend_busy;
   frontend_packet_t out_packet;
   logic             out_valid;
   logic             out_ready;
   logic [PTR_W:0]   count;

   modport master (
      output flush, in_packet, frontend_busy, out_ready,
      input  backend_busy, out_packet, out_valid, count
   );

   modport slave (
      input  flush, in_packet, frontend_busy, out_ready,
      output backend_busy, out_packet, out_valid, count
   );

endinterface

// File: rtl/fb_packet_fifo.sv
// Packet FIFO between the frontend ISU stage and the backend, first-word fall-through.
// Latency: enqueue to out_valid is one cycle; no empty-queue bypass.
// Backpressure: backend_busy is the registered full flag; a full queue never accepts, even while popping.
module fb_packet_fifo
   import bundle::*;
#(
   parameter int DEPTH = FB_FIFO_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   fb_packet_fifo_if.slave    fifo_if
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   frontend_packet_t storage [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count_q;

   logic full;
   logic empty;
   logic enq;
   logic deq;

   // full depends only on the count register, so backend_busy has no comb path from inputs
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   assign enq = fifo_if.in_packet.valid & ~fifo_if.frontend_busy & ~full & ~fifo_if.flush;
   assign deq = ~empty & fifo_if.out_ready & ~fifo_if.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else if (fifo_if.flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (enq) begin
            tail <= tail + PTR_ONE;
         end
         if (deq) begin
            head <= head + PTR_ONE;
         end
         case ({enq, deq})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload needs no reset: an entry is only visible while count covers it.
   always_ff @(posedge clk) begin
      if (enq) begin
         storage[tail] <= fifo_if.in_packet;
      end
   end

   assign fifo_if.out_valid    = ~empty;
   assign fifo_if.out_packet   = empty ? '0 : storage[head];
   assign fifo_if.backend_busy = full;
   assign fifo_if.count        = count_q;

endmodule
